// File: rtl/tournament_chooser.sv
// tournament_chooser
//   Chooser table for a tournament branch predictor. Each entry is a
//   saturating counter that records whether the global or the local
//   component predictor has been more accurate for that index. A lookup
//   returns which component to trust and the resulting direction. A
//   resolve-time update nudges the counter towards the component that was
//   right, and only when exactly one of the two was right.
//
// Parameters
//   HIST_W  index width; the table has DEPTH = 2**HIST_W entries
//   CTR_W   counter width (2..4); MID = 2**(CTR_W-1), MAX = 2**CTR_W-1
//   USE_PC  0: index = history, 1: index = history ^ pc
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   ready               high while the table is initialised (RUN state)
//   pred_valid          lookup request for this cycle
//   pred_history/pc     index sources
//   pred_global/local   the two component predictions
//   pred_out_valid      registered lookup result valid (1-cycle latency)
//   pred_taken          chosen direction
//   pred_use_global     1 when the chooser picked the global component
//   pred_index          index used; returned later as upd_index
//   upd_valid           training request for this cycle
//   upd_index           index to train
//   upd_global_correct  global component was right
//   upd_local_correct   local component was right
//   dbg_state           current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: there is no back-pressure. While ready is high, every cycle
// with pred_valid high is a lookup whose result appears with
// pred_out_valid high one cycle later, and every cycle with upd_valid high
// is a training step. While ready is low both requests are dropped.

module tournament_chooser #(
    parameter int HIST_W = 12,
    parameter int CTR_W  = 3,
    parameter int USE_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [HIST_W-1:0] pred_history,
    input  logic [HIST_W-1:0] pred_pc,
    input  logic              pred_global,
    input  logic              pred_local,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic              pred_use_global,
    output logic [HIST_W-1:0] pred_index,
    input  logic              upd_valid,
    input  logic [HIST_W-1:0] upd_index,
    input  logic              upd_global_correct,
    input  logic              upd_local_correct,
    output logic              dbg_state
);

    localparam int DEPTH = 1 << HIST_W;

    localparam logic [CTR_W-1:0]  CTR_MID  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]  CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [HIST_W-1:0] PTR_ONE  = {{(HIST_W-1){1'b0}}, 1'b1};
    localparam logic [HIST_W-1:0] PTR_LAST = {HIST_W{1'b1}};

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [HIST_W-1:0] ptr;
    logic [CTR_W-1:0]  table_q [DEPTH];

    logic [HIST_W-1:0] lookup_idx;
    logic [CTR_W-1:0]  lookup_ctr;
    logic [CTR_W-1:0]  upd_cur;
    logic [CTR_W-1:0]  upd_next;

    assign ready     = (state == S_RUN);
    assign dbg_state = state;

    assign lookup_idx = (USE_PC != 0) ? (pred_history ^ pred_pc) : pred_history;
    assign lookup_ctr = table_q[lookup_idx];
    assign upd_cur    = table_q[upd_index];

    // Move towards the component that was right; agreement (both right or
    // both wrong) carries no information about which one to trust.
    always_comb begin
        upd_next = upd_cur;
        if (upd_global_correct && !upd_local_correct) begin
            if (upd_cur != CTR_MAX) upd_next = upd_cur + CTR_ONE;
        end else if (upd_local_correct && !upd_global_correct) begin
            if (upd_cur != CTR_ZERO) upd_next = upd_cur - CTR_ONE;
        end
    end

    // The table itself is not reset: the INIT walk rewrites every entry
    // after each reset, so its power-up contents never matter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_INIT;
            ptr             <= '0;
            pred_out_valid  <= 1'b0;
            pred_taken      <= 1'b0;
            pred_use_global <= 1'b0;
            pred_index      <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    table_q[ptr]   <= CTR_MID;
                    ptr            <= ptr + PTR_ONE;
                    pred_out_valid <= 1'b0;
                    if (ptr == PTR_LAST) state <= S_RUN;
                end
                S_RUN: begin
                    pred_out_valid <= pred_valid;
                    if (pred_valid) begin
                        // Reads the pre-update value even when an update
                        // targets the same entry on this edge.
                        pred_use_global <= (lookup_ctr >= CTR_MID);
                        pred_taken      <= (lookup_ctr >= CTR_MID) ? pred_global : pred_local;
                        pred_index      <= lookup_idx;
                    end
                    if (upd_valid) table_q[upd_index] <= upd_next;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tournament_chooser.sv
// tb_tournament_chooser
//   Directed bench for tournament_chooser with HIST_W=4, CTR_W=3
//   (DEPTH=16, MID=4, MAX=7). A second instance with USE_PC=1 shares all
//   inputs so the hashed index can be checked side by side.

module tb_tournament_chooser;

    logic       clock;
    logic       reset;
    logic       pred_valid;
    logic [3:0] pred_history;
    logic [3:0] pred_pc;
    logic       pred_global;
    logic       pred_local;
    logic       upd_valid;
    logic [3:0] upd_index;
    logic       upd_global_correct;
    logic       upd_local_correct;

    logic       ready,      ready_pc;
    logic       out_valid,  out_valid_pc;
    logic       taken,      taken_pc;
    logic       use_global, use_global_pc;
    logic [3:0] index,      index_pc;
    logic       state,      state_pc;

    int n_cmp;
    int n_err;

    tournament_chooser #(.HIST_W(4), .CTR_W(3), .USE_PC(0)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .pred_valid(pred_valid), .pred_history(pred_history), .pred_pc(pred_pc),
        .pred_global(pred_global), .pred_local(pred_local),
        .pred_out_valid(out_valid), .pred_taken(taken),
        .pred_use_global(use_global), .pred_index(index),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_global_correct(upd_global_correct), .upd_local_correct(upd_local_correct),
        .dbg_state(state)
    );

    tournament_chooser #(.HIST_W(4), .CTR_W(3), .USE_PC(1)) dut_pc (
        .clock(clock), .reset(reset), .ready(ready_pc),
        .pred_valid(pred_valid), .pred_history(pred_history), .pred_pc(pred_pc),
        .pred_global(pred_global), .pred_local(pred_local),
        .pred_out_valid(out_valid_pc), .pred_taken(taken_pc),
        .pred_use_global(use_global_pc), .pred_index(index_pc),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_global_correct(upd_global_correct), .upd_local_correct(upd_local_correct),
        .dbg_state(state_pc)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, well clear of the next edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        pred_valid = 0; pred_history = 0; pred_pc = 0; pred_global = 0; pred_local = 0;
        upd_valid = 0; upd_index = 0; upd_global_correct = 0; upd_local_correct = 0;
    endtask

    task automatic drive(input logic pv, input logic [3:0] hist, input logic [3:0] pc,
                         input logic g, input logic l, input logic uv,
                         input logic [3:0] ui, input logic gc, input logic lc);
        pred_valid = pv; pred_history = hist; pred_pc = pc; pred_global = g; pred_local = l;
        upd_valid = uv; upd_index = ui; upd_global_correct = gc; upd_local_correct = lc;
        tick();
        clear_inputs();
    endtask

    task automatic lookup(input logic [3:0] hist, input logic g, input logic l);
        drive(1, hist, 4'd0, g, l, 0, 4'd0, 0, 0);
    endtask

    task automatic update(input logic [3:0] ui, input logic gc, input logic lc, input int n);
        for (int k = 0; k < n; k++) drive(0, 4'd0, 4'd0, 0, 0, 1, ui, gc, lc);
    endtask

    task automatic check_result(input string tag, input logic exp_use, input logic exp_taken,
                                input logic [3:0] exp_idx);
        check_eq({tag, ".valid"}, out_valid, 1);
        check_eq({tag, ".use_global"}, use_global, exp_use);
        check_eq({tag, ".taken"}, taken, exp_taken);
        check_eq({tag, ".index"}, index, exp_idx);
    endtask

    task automatic walk_init(input string tag);
        for (int i = 0; i < 16; i++) begin
            pred_valid = i[0];
            pred_history = 4'(i);
            pred_global = 1;
            tick();
            check_eq({tag, ".ready"}, ready, (i == 15));
            check_eq({tag, ".out_valid"}, out_valid, 0);
        end
        clear_inputs();
        check_eq({tag, ".state"}, state, 1);
        check_eq({tag, ".ready_pc"}, ready_pc, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();

        // reset values
        reset = 1;
        tick();
        check_eq("rst.ready", ready, 0);
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.taken", taken, 0);
        check_eq("rst.use_global", use_global, 0);
        check_eq("rst.index", index, 0);
        check_eq("rst.state", state, 0);
        reset = 0;

        walk_init("init");

        // fresh entry is MID -> global chosen
        lookup(4'd5, 1, 0);
        check_result("lk5_first", 1, 1, 4'd5);
        drive(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0);
        check_eq("idle.out_valid", out_valid, 0);
        check_eq("idle.taken_hold", taken, 1);
        check_eq("idle.index_hold", index, 5);
        check_eq("idle.use_hold", use_global, 1);

        // idx 5: 4 -> 3 -> local chosen
        update(4'd5, 0, 1, 1);
        lookup(4'd5, 1, 0);
        check_result("lk5_ctr3a", 0, 0, 4'd5);
        lookup(4'd5, 0, 1);
        check_result("lk5_ctr3b", 0, 1, 4'd5);

        // down to 0 and one more (must stay 0)
        update(4'd5, 0, 1, 4);
        lookup(4'd5, 1, 0);
        check_result("lk5_ctr0", 0, 0, 4'd5);
        // 0 + 3 = 3 (a wrap to 7 would give global here)
        update(4'd5, 1, 0, 3);
        lookup(4'd5, 1, 0);
        check_result("lk5_ctr3c", 0, 0, 4'd5);
        update(4'd5, 1, 0, 1);
        lookup(4'd5, 0, 1);
        check_result("lk5_ctr4", 1, 0, 4'd5);

        // idx 9: saturate at 7, agreement leaves it alone
        update(4'd9, 1, 0, 5);
        lookup(4'd9, 0, 1);
        check_result("lk9_ctr7", 1, 0, 4'd9);
        update(4'd9, 1, 1, 2);
        update(4'd9, 0, 0, 2);
        // same-cycle lookup sees 7, update commits 6
        drive(1, 4'd9, 4'd0, 1, 0, 1, 4'd9, 0, 1);
        check_result("lk9_bypass", 1, 1, 4'd9);
        lookup(4'd9, 1, 0);
        check_result("lk9_ctr6", 1, 1, 4'd9);
        update(4'd9, 0, 1, 2);
        lookup(4'd9, 1, 0);
        check_result("lk9_ctr4", 1, 1, 4'd9);
        update(4'd9, 0, 1, 1);
        lookup(4'd9, 1, 0);
        check_result("lk9_ctr3", 0, 0, 4'd9);

        // update to 12 while looking up 5 (ctr 4)
        drive(1, 4'd5, 4'd0, 1, 0, 1, 4'd12, 0, 1);
        check_result("lk5_other_upd", 1, 1, 4'd5);
        lookup(4'd12, 1, 0);
        check_result("lk12_ctr3", 0, 0, 4'd12);
        lookup(4'd5, 1, 0);
        check_result("lk5_untouched", 1, 1, 4'd5);

        // pc hashing: plain instance uses 1010 (ctr 4), hashed uses 1001 (idx 9, ctr 3)
        drive(1, 4'b1010, 4'b0011, 1, 0, 0, 4'd0, 0, 0);
        check_result("pc_plain", 1, 1, 4'b1010);
        check_eq("pc_hash.valid", out_valid_pc, 1);
        check_eq("pc_hash.index", index_pc, 4'b1001);
        check_eq("pc_hash.use_global", use_global_pc, 0);
        check_eq("pc_hash.taken", taken_pc, 0);

        // train idx 5 (ctr 4) to 0, run 3 cycles, then reset
        update(4'd5, 0, 1, 4);
        lookup(4'd5, 1, 0);
        check_result("lk5_pre_rst", 0, 0, 4'd5);
        for (int i = 0; i < 3; i++) tick();
        reset = 1;
        drive(1, 4'd5, 4'd0, 1, 1, 1, 4'd5, 0, 1);
        check_eq("rst2.ready", ready, 0);
        check_eq("rst2.out_valid", out_valid, 0);
        check_eq("rst2.taken", taken, 0);
        check_eq("rst2.use_global", use_global, 0);
        check_eq("rst2.index", index, 0);
        check_eq("rst2.state", state, 0);
        reset = 0;
        walk_init("reinit");
        lookup(4'd5, 0, 1);
        check_result("lk5_after_rst", 1, 0, 4'd5);
        check_eq("pc_after_rst.index", index_pc, 4'd5);
        check_eq("pc_after_rst.use_global", use_global_pc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tournament_chooser.md
TOURNAMENT_CHOOSER -- requirements
Module: tournament_chooser

Interface
REQ-001 SHALL have parameter HIST_W, default 12, meaning index width; table depth DEPTH = 2^HIST_W.
REQ-002 SHALL have parameter CTR_W, default 3, meaning width of each saturating chooser counter (legal range 2..4).
REQ-003 SHALL have parameter USE_PC, default 0, meaning 0 = index is history; 1 = index is history XOR pc.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ready  output  1  high once table initialisation is complete.
REQ-007 SHALL have ports pred_valid (input, 1), pred_history (input, HIST_W), pred_pc (input, HIST_W), pred_global (input, 1) and pred_local (input, 1): lookup request plus the two component predictions.
REQ-008 SHALL have ports pred_out_valid (output, 1), pred_taken (output, 1), pred_use_global (output, 1) and pred_index (output, HIST_W): registered lookup result and the index the caller returns at resolve time.
REQ-009 SHALL have ports upd_valid (input, 1), upd_index (input, HIST_W), upd_global_correct (input, 1) and upd_local_correct (input, 1): resolve/training request.

Function
REQ-010 SHALL hold a DEPTH x CTR_W counter table; MID = 2^(CTR_W-1); MAX = 2^CTR_W-1.
REQ-011 SHALL implement a two-state FSM, INIT and RUN; reset forces INIT with walk pointer 0.
REQ-012 In INIT, SHALL write MID to entry [pointer] on each edge with reset low, then increment pointer; on the edge that writes entry DEPTH-1, SHALL move to RUN.
REQ-013 SHALL drive ready = 1 exactly while in RUN.
REQ-014 In INIT, SHALL ignore pred_valid and upd_valid, and SHALL hold pred_out_valid at 0.
REQ-015 SHALL compute idx = pred_history when USE_PC = 0, and idx = pred_history XOR pred_pc when USE_PC = 1.
REQ-016 In RUN with pred_valid = 1, SHALL register on the next edge: pred_out_valid = 1; pred_use_global = (table[idx] >= MID); pred_taken = pred_use_global ? pred_global : pred_local; pred_index = idx.
REQ-017 In RUN with pred_valid = 0, SHALL set pred_out_valid = 0 on the next edge and hold the other outputs.
REQ-018 Lookup latency SHALL be exactly 1 cycle, with no back-pressure; one lookup per cycle.
REQ-019 In RUN with upd_valid = 1, SHALL train table[upd_index] only when the component outcomes differ.
REQ-020 When global is correct and local wrong, SHALL increment the counter, saturating at MAX.
REQ-021 When local is correct and global wrong, SHALL decrement the counter, saturating at 0.
REQ-022 When both components are correct or both are wrong, SHALL leave the counter unchanged.
REQ-023 When an update and a lookup hit the same index on one edge, the lookup SHALL see the pre-update value, and the update SHALL still commit.
REQ-024 An update to an index different from the lookup index SHALL not affect that lookup result.
REQ-025 Counter arithmetic SHALL never wrap: MAX+1 stays MAX, and 0-1 stays 0.

Reset
REQ-026 When reset is high at an edge, SHALL set ready = 0, pred_out_valid = 0, pred_taken = 0, pred_use_global = 0, pred_index = 0, state = INIT and pointer = 0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL abandon the walk or any in-flight lookup and restart the full INIT walk from entry 0; updates present during reset SHALL be discarded.
REQ-028 Table contents SHALL be defined only through INIT writes; no dependence on simulator initial values.

Verification (HIST_W=4, CTR_W=3, DEPTH=16, MID=4, MAX=7)
REQ-029 Reset 1 cycle, then release -> ready = 0 for 16 edges, ready = 1 after the 16th edge; pred_valid pulses during INIT give pred_out_valid = 0.
REQ-030 After init, lookup idx 5 with pred_global = 1, pred_local = 0 -> next cycle pred_out_valid = 1, pred_use_global = 1, pred_taken = 1, pred_index = 5.
REQ-031 Four updates to idx 5 with local correct and global wrong -> counter 4->3->2->1->0, stays 0 on a 5th update; lookup then gives pred_use_global = 0 and pred_taken = pred_local.
REQ-032 Five updates to idx 9 with global correct and local wrong -> counter saturates at 7; updates with both correct or both wrong leave 7; a same-cycle lookup plus local-correct update on idx 9 returns pred_use_global = 1, and the next lookup sees 6 (still global).
REQ-033 USE_PC = 1, history 4'b1010, pc 4'b0011 -> pred_index = 4'b1001.
REQ-034 Reset asserted 3 cycles into RUN after training idx 5 to 0 -> ready drops, 16-cycle walk repeats, and lookup of idx 5 shows pred_use_global = 1 (counter back to MID).
